// File: rtl/fifo_write_arbiter_if.sv
// Bundles the requester streams and the FIFO write port shared by the arbiter.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        grant;
   logic                      push;
   logic [DATA_W-1:0]         wr_data;
   logic                      full;
   logic                      busy;
   logic                      burst_err;

   modport slave (
      input  req_valid, req_data, req_last, full,
      output req_ready, grant, push, wr_data, busy, burst_err
   );

   modport master (
      output req_valid, req_data, req_last, full,
      input  req_ready, grant, push, wr_data, busy, burst_err
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ burst streams.
// Grants are locked for a whole burst; a beat-limit watchdog forces release.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   fifo_write_arbiter_if.slave io_bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t             r_state, w_state_next;
   logic [NUM_REQ-1:0] r_grant, w_grant_next;
   logic [IDX_W-1:0]   r_last_win, w_last_win_next;
   logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_next;
   logic               r_burst_err, w_burst_err_next;

   logic [IDX_W-1:0]   w_gidx;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_found;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic               w_beat_acc;
   logic               w_at_limit;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [DATA_W-1:0]  w_wr_data;

   // Grant is one-hot (or zero), so OR-ing masked lanes forms the data mux.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_gidx    = '0;
      w_wr_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_gidx    = IDX_W'(i);
            w_wr_data = w_wr_data | io_bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_sel_valid = |(r_grant & io_bus.req_valid);
   assign w_sel_last  = |(r_grant & io_bus.req_last);
   assign w_beat_acc  = w_sel_valid && !io_bus.full;
   assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
   assign w_at_limit  = (w_cnt_inc == CNT_W'(MAX_BURST));

   // Scan from last_win+1 upward with wrap; first asserted requester wins.
   always_comb begin
      logic [IDX_W-1:0] pos;
      pos         = '0;
      w_win_idx   = '0;
      w_win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = IDX_W'((int'(r_last_win) + k) % NUM_REQ);
         if (!w_win_found && io_bus.req_valid[pos]) begin
            w_win_found = 1'b1;
            w_win_idx   = pos;
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_grant_next     = r_grant;
      w_last_win_next  = r_last_win;
      w_beat_cnt_next  = r_beat_cnt;
      w_burst_err_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_beat_cnt_next = '0;
            if (w_win_found) begin
               w_state_next = S_BURST;
               w_grant_next = NUM_REQ'(1) << w_win_idx;
            end
         end
         S_BURST: begin
            if (w_beat_acc) begin
               w_beat_cnt_next = w_cnt_inc;
               if (w_sel_last || w_at_limit) begin
                  w_state_next     = S_IDLE;
                  w_grant_next     = '0;
                  w_last_win_next  = w_gidx;
                  w_burst_err_next = !w_sel_last;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_last_win  <= IDX_W'(NUM_REQ - 1);
         r_beat_cnt  <= '0;
         r_burst_err <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         r_state     <= w_state_next;
         r_grant     <= w_grant_next;
         r_last_win  <= w_last_win_next;
         r_beat_cnt  <= w_beat_cnt_next;
         r_burst_err <= w_burst_err_next;
      end
   end

   assign io_bus.grant     = r_grant;
   assign io_bus.busy      = (r_state == S_BURST);
   assign io_bus.req_ready = io_bus.full ? '0 : r_grant;
   assign io_bus.push      = w_beat_acc;
   assign io_bus.wr_data   = w_wr_data;
   assign io_bus.burst_err = r_burst_err;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: inputs change on the falling edge,
// outputs are compared 1 time unit later, well away from the rising edge.
module tb_fifo_write_arbiter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(int i, logic v, logic [31:0] d, logic l);
      bus.req_valid[i]          = v;
      bus.req_data[i*32 +: 32]  = d;
      bus.req_last[i]           = l;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // g is the expected grant; a nonzero grant here implies an accepted beat of data d.
   task automatic expect_beat(string tag, logic [3:0] g, logic [31:0] d);
      check({tag, ".grant"}, 32'(bus.grant), 32'(g));
      check({tag, ".busy"},  32'(bus.busy),  32'(g != 4'd0));
      check({tag, ".push"},  32'(bus.push),  32'(g != 4'd0));
      if (g != 4'd0) check({tag, ".data"}, bus.wr_data, d);
   endtask

   initial begin
      int b;
      int pushes;
      logic f;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.full      = 1'b0;

      // Reset values
      #2;
      check("rst.grant", 32'(bus.grant), 32'h0);
      check("rst.ready", 32'(bus.req_ready), 32'h0);
      check("rst.push",  32'(bus.push), 32'h0);
      check("rst.data",  bus.wr_data, 32'h0);
      check("rst.busy",  32'(bus.busy), 32'h0);
      check("rst.err",   32'(bus.burst_err), 32'h0);
      step();
      rst_n = 1'b1;

      // Single requester, 3-beat burst
      step();
      drive(2, 1'b1, 32'h11, 1'b0);
      #1;
      expect_beat("single.arb", 4'b0000, 32'h0);
      step(); drive(2, 1'b1, 32'h11, 1'b0); #1;
      expect_beat("single.b0", 4'b0100, 32'h11);
      check("single.ready", 32'(bus.req_ready), 32'h4);
      step(); drive(2, 1'b1, 32'h22, 1'b0); #1;
      expect_beat("single.b1", 4'b0100, 32'h22);
      step(); drive(2, 1'b1, 32'h33, 1'b1); #1;
      expect_beat("single.b2", 4'b0100, 32'h33);
      step(); drive(2, 1'b0, 32'h0, 1'b0); #1;
      expect_beat("single.rel", 4'b0000, 32'h0);

      // All four after reset, 1-beat bursts: order 0,1,2,3,0 with idle bubbles
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 32'hA0 + i, 1'b1);
      #1;
      expect_beat("rr.arb", 4'b0000, 32'h0);
      for (int k = 0; k < 9; k++) begin
         step(); #1;
         if (k % 2 == 0)
            expect_beat($sformatf("rr.k%0d", k), 4'(1 << ((k / 2) % 4)), 32'hA0 + (k / 2) % 4);
         else
            expect_beat($sformatf("rr.k%0d", k), 4'b0000, 32'h0);
      end
      step();
      for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 1'b0);
      #1;
      expect_beat("rr.end", 4'b0000, 32'h0);

      // Backpressure: requester 1, 8 beats, full for three cycles from beat 3
      step();
      drive(1, 1'b1, 32'h100, 1'b0);
      #1;
      expect_beat("bp.arb", 4'b0000, 32'h0);
      b = 0;
      pushes = 0;
      for (int c = 0; c < 11; c++) begin
         step();
         f = (c >= 2 && c <= 4);
         bus.full = f;
         drive(1, 1'b1, 32'h100 + b, (b == 7));
         #1;
         check($sformatf("bp.c%0d.grant", c), 32'(bus.grant), 32'h2);
         check($sformatf("bp.c%0d.ready", c), 32'(bus.req_ready), f ? 32'h0 : 32'h2);
         check($sformatf("bp.c%0d.push", c),  32'(bus.push), 32'(!f));
         if (!f) check($sformatf("bp.c%0d.data", c), bus.wr_data, 32'h100 + b);
         if (bus.push) pushes++;
         if (!f) b++;
      end
      check("bp.pushes", 32'(pushes), 32'd8);
      step();
      bus.full = 1'b0;
      drive(1, 1'b0, 32'h0, 1'b0);
      #1;
      expect_beat("bp.rel", 4'b0000, 32'h0);

      // Runaway: requester 2 sends 20 beats without last; 3,0,1 also waiting
      step();
      drive(2, 1'b1, 32'h200, 1'b0);
      drive(3, 1'b1, 32'hC3, 1'b1);
      drive(0, 1'b1, 32'hC0, 1'b1);
      drive(1, 1'b1, 32'hC1, 1'b1);
      #1;
      expect_beat("run.arb", 4'b0000, 32'h0);
      for (int n = 0; n < 16; n++) begin
         step();
         drive(2, 1'b1, 32'h200 + n, 1'b0);
         #1;
         expect_beat($sformatf("run.b%0d", n), 4'b0100, 32'h200 + n);
         check($sformatf("run.b%0d.err", n), 32'(bus.burst_err), 32'h0);
      end
      step();
      drive(2, 1'b1, 32'h210, 1'b0);
      #1;
      expect_beat("run.forced", 4'b0000, 32'h0);
      check("run.err_pulse", 32'(bus.burst_err), 32'h1);
      step(); #1;
      expect_beat("run.g3", 4'b1000, 32'hC3);
      check("run.err_end", 32'(bus.burst_err), 32'h0);
      step(); drive(3, 1'b0, 32'h0, 1'b0); #1;
      expect_beat("run.idle3", 4'b0000, 32'h0);
      step(); #1;
      expect_beat("run.g0", 4'b0001, 32'hC0);
      step(); drive(0, 1'b0, 32'h0, 1'b0); #1;
      expect_beat("run.idle0", 4'b0000, 32'h0);
      step(); #1;
      expect_beat("run.g1", 4'b0010, 32'hC1);
      step(); drive(1, 1'b0, 32'h0, 1'b0); #1;
      expect_beat("run.idle1", 4'b0000, 32'h0);
      for (int m = 0; m < 4; m++) begin
         step();
         drive(2, 1'b1, 32'h210 + m, (m == 3));
         #1;
         expect_beat($sformatf("run.rest%0d", m), 4'b0100, 32'h210 + m);
      end
      step();
      drive(2, 1'b0, 32'h0, 1'b0);
      #1;
      expect_beat("run.done", 4'b0000, 32'h0);
      check("run.no_err", 32'(bus.burst_err), 32'h0);

      // Reset during beat 2 of a 5-beat burst from requester 0
      step();
      drive(0, 1'b1, 32'h300, 1'b0);
      #1;
      expect_beat("mid.arb", 4'b0000, 32'h0);
      step(); drive(0, 1'b1, 32'h300, 1'b0); #1;
      expect_beat("mid.b0", 4'b0001, 32'h300);
      step(); drive(0, 1'b1, 32'h301, 1'b0); #1;
      rst_n = 1'b0;
      #1;
      check("mid.grant", 32'(bus.grant), 32'h0);
      check("mid.ready", 32'(bus.req_ready), 32'h0);
      check("mid.push",  32'(bus.push), 32'h0);
      check("mid.data",  bus.wr_data, 32'h0);
      check("mid.busy",  32'(bus.busy), 32'h0);
      check("mid.err",   32'(bus.burst_err), 32'h0);
      step();
      rst_n = 1'b1;
      drive(0, 1'b1, 32'h3A0, 1'b1);
      drive(3, 1'b1, 32'h3B0, 1'b1);
      #1;
      expect_beat("mid.arb2", 4'b0000, 32'h0);
      step(); #1;
      expect_beat("mid.prio0", 4'b0001, 32'h3A0);
      step();
      drive(0, 1'b0, 32'h0, 1'b0);
      drive(3, 1'b0, 32'h0, 1'b0);
      #1;
      expect_beat("mid.idle", 4'b0000, 32'h0);

      // Last beat exactly on beat 16: normal release, no error
      step();
      drive(1, 1'b1, 32'h400, 1'b0);
      #1;
      expect_beat("lim.arb", 4'b0000, 32'h0);
      for (int n = 0; n < 16; n++) begin
         step();
         drive(1, 1'b1, 32'h400 + n, (n == 15));
         #1;
         expect_beat($sformatf("lim.b%0d", n), 4'b0010, 32'h400 + n);
      end
      step();
      drive(1, 1'b0, 32'h0, 1'b0);
      #1;
      expect_beat("lim.rel", 4'b0000, 32'h0);
      check("lim.err0", 32'(bus.burst_err), 32'h0);
      step(); #1;
      check("lim.err1", 32'(bus.burst_err), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the 16-entry, 32-bit FIFO between four requesters. Each requester presents a valid/ready/last burst stream. The arbiter locks the grant for a whole burst, drives the FIFO `push`/`wr_data` and honours `full` as backpressure. A beat-limit watchdog force-releases runaway bursts and flags them.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, data width
- `MAX_BURST`, 16, maximum beats per burst before forced release (1..256)

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_data`  in  NUM_REQ*DATA_W  per-requester beat data; requester i at bits [i*DATA_W +: DATA_W]
- `req_last`  in  NUM_REQ  final beat of the requester's burst
- `req_ready`  out  NUM_REQ  beat accepted when `req_valid[i] && req_ready[i]`
- `grant`  out  NUM_REQ  registered one-hot grant, zero when idle
- `push`  out  1  FIFO write strobe
- `wr_data`  out  DATA_W  FIFO write data
- `full`  in  1  FIFO full
- `busy`  out  1  high while a burst is granted (state BURST)
- `burst_err`  out  1  one-cycle pulse on forced release

## Operation
- FSM states are IDLE and BURST.
- Round-robin pointer `last_win` resets to NUM_REQ-1, so requester 0 has top priority after reset.
- **IDLE**
  - If any `req_valid`, select the first asserted requester scanning from `last_win+1` upward, with modulo NUM_REQ wrap.
  - Register its one-hot `grant` and go to BURST.
  - Otherwise stay in IDLE with `grant`=0.
- **BURST**, with granted index g:
  - `req_ready[g] = !full`; all other `req_ready` bits are 0.
  - `push = req_valid[g] && !full`.
  - `wr_data = req_data[g]` as a combinational mux from the registered grant.
  - A non-granted `req_ready` or `push` is never asserted.
- **Beat counter**
  - Counter width is clog2(MAX_BURST+1). It clears on entry to BURST and increments on each accepted beat.
- **Release**
  - Release happens on an accepted beat with `req_last[g]`, or on the accepted beat that makes the counter equal MAX_BURST, whichever comes first.
  - On release: `grant`←0, `last_win`←g, next state IDLE.
  - If release is caused by the limit and `req_last[g]` is low, pulse `burst_err` for 1 cycle.
  - A last beat landing exactly on beat MAX_BURST is a normal release with no error.
- **Granted requester drops `req_valid` mid-burst:** the grant is held and no push occurs. There is no timeout.
- **`full` high:** no beat is accepted and the counter holds. The burst resumes the cycle `full` drops.
- Requester inputs are ignored outside BURST for the granted index. Changing `req_data`/`req_last` while valid and not ready is a protocol violation, and behaviour is unspecified.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `push`=0, `wr_data`=0, `busy`=0, `burst_err`=0, state IDLE, counter 0, `last_win`=NUM_REQ-1.
- Reset asserted mid-burst aborts immediately. Beats not yet accepted are not pushed, and no `burst_err` is raised.
- Grant latency: `req_valid` sampled in IDLE at edge N gives `grant`/`busy` high after edge N. The first push is possible in cycle N+1.
- Every burst is followed by exactly one IDLE cycle (arbitration bubble). Back-to-back single-beat bursts therefore sustain 1 beat per 2 cycles.
- Throughput inside a burst is 1 beat/cycle while `!full`.
- `req_ready` and `push` are combinational from state, `grant`, `full` and `req_valid[g]`. There is no combinational path from any `req_valid` to `grant`.
- `burst_err` is asserted in the cycle after the forcing beat and lasts exactly 1 cycle.

## Test plan
- **Single requester:** `req_valid`=4'b0100, 3 beats 0x11,0x22,0x33, last on the third → `grant`=4'b0100 one cycle later; `push` 3 cycles with `wr_data` 0x11,0x22,0x33; `grant`=0 next cycle.
- **All four request after reset**, each sending 1-beat bursts repeatedly → grant order 0,1,2,3,0; each grant is separated by one idle cycle; FIFO receives beats in that order.
- **Backpressure:** requester 1 sends an 8-beat burst with `full` high for beats 3–5 → `req_ready[1]`=`push`=0 while full; all 8 beats are written in order; no beat is duplicated or dropped.
- **Runaway burst:** requester 2 sends 20 beats with no last, MAX_BURST=16 → 16 pushes; `burst_err` pulses once; grant is released; requester 2 re-arbitrates and receives its remaining beats only after requesters 3,0,1 if they are requesting.
- **Reset mid-burst:** `rst_n` low during beat 2 of a 5-beat burst → all outputs 0 asynchronously; after release requester 0 has priority over simultaneous requesters 0 and 3.
- **Exact-limit last:** last on beat 16 with MAX_BURST=16 → normal release; `burst_err` stays 0.
